// File: rtl/sm2_mod_op_issuer.sv
// sm2_mod_op_issuer
//   Front-end issuer for the SM2 modular arithmetic datapath. Takes one
//   MUL/ADD/SUB request at a time, builds the 512-bit product for MUL with an
//   iterative MUL_W-bit slice multiplier, drives the fast-reduction block's
//   start/operand interface, waits for its finish strobe (bounded by TIMEOUT)
//   and returns the 256-bit result on a valid/ready response port.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   req_vld_i/req_rdy_o request handshake (ready only in IDLE)
//   req_op_i            00 MUL, 01 ADD, 10 SUB, 11 illegal
//   req_a_i, req_b_i    256-bit operands (< p)
//   rsp_vld_o/rsp_rdy_i response handshake
//   rsp_res_o           256-bit result
//   rsp_err_o           illegal op or reducer timeout
//   mod_vld_o           start level to reducer (reducer starts on rising edge)
//   op_sel_o            op code to reducer, changes only at accept
//   p512_a_o            MUL: product; ADD/SUB: {a,b}
//   mod_fin_i           reducer finish strobe
//   mul_res_i           reducer MUL result
//   add_sub_res_i       reducer ADD/SUB result
module sm2_mod_op_issuer #(
  parameter int MUL_W   = 64,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_vld_i,
  output logic         req_rdy_o,
  input  logic [1:0]   req_op_i,
  input  logic [255:0] req_a_i,
  input  logic [255:0] req_b_i,
  output logic         rsp_vld_o,
  input  logic         rsp_rdy_i,
  output logic [255:0] rsp_res_o,
  output logic         rsp_err_o,
  output logic         mod_vld_o,
  output logic [1:0]   op_sel_o,
  output logic [511:0] p512_a_o,
  input  logic         mod_fin_i,
  input  logic [255:0] mul_res_i,
  input  logic [255:0] add_sub_res_i
);

  localparam int N      = 256 / MUL_W;
  localparam int CNT_W  = $clog2(TIMEOUT + N + 1) + 1;
  localparam int PROD_W = 256 + MUL_W;

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_WAIT, S_RESP} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [255:0]       a_q;
  logic [255:0]       b_sh;     // b shifted right one slice per MUL cycle
  logic [511:0]       acc;
  logic [511:0]       acc_sum;
  logic [CNT_W-1:0]   cnt;      // slice index in MUL, wait cycles in WAIT
  logic               mul_last;
  logic               timeout;
  logic [255:0]       red_res;

  // One partial product a * b_slice placed at slice position k.
  function automatic logic [511:0] slice_term(input logic [255:0]     a,
                                              input logic [MUL_W-1:0] b_slice,
                                              input logic [CNT_W-1:0] k);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(a) * PROD_W'(b_slice);
    return 512'(prod) << (32'(k) * MUL_W);
  endfunction

  assign req_rdy_o = (state == S_IDLE);
  assign mul_last  = (state == S_MUL)  && (cnt == CNT_W'(N - 1));
  assign timeout   = (state == S_WAIT) && (cnt == CNT_W'(TIMEOUT));
  assign acc_sum   = acc + slice_term(a_q, b_sh[MUL_W-1:0], cnt);
  // op_sel_o is stable through WAIT, so it tells which reducer result is live
  assign red_res   = (op_sel_o == OP_MUL) ? mul_res_i : add_sub_res_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req_vld_i) begin
          case (req_op_i)
            OP_MUL:         state_nxt = S_MUL;
            OP_ADD, OP_SUB: state_nxt = S_WAIT;
            default:        state_nxt = S_RESP;
          endcase
        end
      end
      S_MUL:   if (mul_last) state_nxt = S_WAIT;
      S_WAIT:  if (mod_fin_i || timeout) state_nxt = S_RESP;
      S_RESP:  if (rsp_rdy_i) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      b_sh      <= '0;
      acc       <= '0;
      cnt       <= '0;
      rsp_vld_o <= 1'b0;
      rsp_res_o <= '0;
      rsp_err_o <= 1'b0;
      mod_vld_o <= 1'b0;
      op_sel_o  <= OP_MUL;
      p512_a_o  <= '0;
    end else begin
      case (state)
        // accept: latch operands, start the reducer directly for ADD/SUB
        S_IDLE: begin
          if (req_vld_i) begin
            a_q      <= req_a_i;
            b_sh     <= req_b_i;
            acc      <= '0;
            cnt      <= '0;
            op_sel_o <= req_op_i;
            case (req_op_i)
              OP_MUL: ;
              OP_ADD, OP_SUB: begin
                p512_a_o  <= {req_a_i, req_b_i};
                mod_vld_o <= 1'b1;
              end
              default: begin
                rsp_res_o <= '0;
                rsp_err_o <= 1'b1;
                rsp_vld_o <= 1'b1;
              end
            endcase
          end
        end
        // iterative multiply: one MUL_W slice of b per cycle
        S_MUL: begin
          acc  <= acc_sum;
          b_sh <= b_sh >> MUL_W;
          cnt  <= cnt + 1'b1;
          if (mul_last) begin
            p512_a_o  <= acc_sum;
            mod_vld_o <= 1'b1;
            cnt       <= '0;
          end
        end
        // reducer running: finish strobe wins over a same-cycle timeout
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          if (mod_fin_i) begin
            rsp_res_o <= red_res;
            rsp_err_o <= 1'b0;
            rsp_vld_o <= 1'b1;
            mod_vld_o <= 1'b0;
          end else if (timeout) begin
            rsp_res_o <= '0;
            rsp_err_o <= 1'b1;
            rsp_vld_o <= 1'b1;
            mod_vld_o <= 1'b0;
          end
        end
        // response held until taken
        S_RESP: begin
          if (rsp_rdy_i) rsp_vld_o <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sm2_mod_op_issuer.sv
module tb_sm2_mod_op_issuer;

  localparam int MUL_W   = 64;
  localparam int TIMEOUT = 15;
  localparam int N       = 256 / MUL_W;
  localparam logic [255:0] P =
    256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;
  localparam logic [511:0] P512 = {256'd0, P};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_vld = 1'b0;
  logic         req_rdy;
  logic [1:0]   req_op = 2'b00;
  logic [255:0] req_a = '0;
  logic [255:0] req_b = '0;
  logic         rsp_vld;
  logic         rsp_rdy = 1'b0;
  logic [255:0] rsp_res;
  logic         rsp_err;
  logic         mod_vld;
  logic [1:0]   op_sel;
  logic [511:0] p512;
  logic         mod_fin;
  logic [255:0] mul_res;
  logic [255:0] add_sub_res;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic stub_on = 1'b1;
  int   red_cnt = 0;

  sm2_mod_op_issuer #(.MUL_W(MUL_W), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_vld_i     (req_vld),
    .req_rdy_o     (req_rdy),
    .req_op_i      (req_op),
    .req_a_i       (req_a),
    .req_b_i       (req_b),
    .rsp_vld_o     (rsp_vld),
    .rsp_rdy_i     (rsp_rdy),
    .rsp_res_o     (rsp_res),
    .rsp_err_o     (rsp_err),
    .mod_vld_o     (mod_vld),
    .op_sel_o      (op_sel),
    .p512_a_o      (p512),
    .mod_fin_i     (mod_fin),
    .mul_res_i     (mul_res),
    .add_sub_res_i (add_sub_res)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reducer stand-in: ADD/SUB answer combinationally, MUL on the 4th high cycle.
  always @(posedge clk) red_cnt <= mod_vld ? red_cnt + 1 : 0;
  assign mod_fin = stub_on && mod_vld && (op_sel != 2'b00 || red_cnt == 3);
  always_comb begin
    logic [511:0] hi;
    logic [511:0] lo;
    hi = {256'd0, p512[511:256]};
    lo = {256'd0, p512[255:0]};
    mul_res = 256'(p512 % P512);
    add_sub_res = (op_sel == 2'b01) ? 256'((hi + lo) % P512)
                                    : 256'((hi + P512 - lo) % P512);
  end

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [255:0] ref_result(input logic [1:0] op, input logic [255:0] a,
                                              input logic [255:0] b);
    logic [511:0] wa;
    logic [511:0] wb;
    wa = {256'd0, a};
    wb = {256'd0, b};
    case (op)
      2'b00:   return 256'((wa * wb) % P512);
      2'b01:   return 256'((wa + wb) % P512);
      2'b10:   return (a >= b) ? a - b : 256'(wa + P512 - wb);
      default: return '0;
    endcase
  endfunction

  function automatic int lat_of(input logic [1:0] op, input logic fin_ok);
    if (op == 2'b11) return 1;
    if (op == 2'b00) return fin_ok ? N + 5 : N + TIMEOUT + 2;
    return fin_ok ? 2 : TIMEOUT + 2;
  endfunction

  typedef enum {M_IDLE, M_BUSY, M_RESP} mst_t;
  mst_t         m_st = M_IDLE;
  logic [1:0]   m_op = 2'b00;
  int           m_age = 0;
  int           m_lat = 0;
  int           m_wstart = 0;
  logic [255:0] m_res = '0;
  logic         m_err = 1'b0;
  logic [511:0] m_p512 = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_st  <= M_IDLE;
      m_op  <= 2'b00;
      m_age <= 0;
    end else begin
      case (m_st)
        M_IDLE: if (req_vld) begin
          m_op     <= req_op;
          m_age    <= 1;
          m_lat    <= lat_of(req_op, stub_on);
          m_wstart <= (req_op == 2'b00) ? N + 1 : 1;
          m_p512   <= (req_op == 2'b00) ? {256'd0, req_a} * {256'd0, req_b} : {req_a, req_b};
          m_res    <= (stub_on && req_op != 2'b11) ? ref_result(req_op, req_a, req_b) : '0;
          m_err    <= (req_op == 2'b11) || !stub_on;
          m_st     <= (lat_of(req_op, stub_on) == 1) ? M_RESP : M_BUSY;
        end
        M_BUSY: begin
          m_age <= m_age + 1;
          if (m_age + 1 == m_lat) m_st <= M_RESP;
        end
        M_RESP: if (rsp_rdy) m_st <= M_IDLE;
        default: m_st <= M_IDLE;
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic exp_mv;
    if (rst) begin
      chk("rst_req_rdy", 512'(req_rdy), 512'(1));
      chk("rst_rsp_vld", 512'(rsp_vld), 512'(0));
      chk("rst_mod_vld", 512'(mod_vld), 512'(0));
      chk("rst_rsp_res", 512'(rsp_res), 512'(0));
      chk("rst_rsp_err", 512'(rsp_err), 512'(0));
      chk("rst_op_sel",  512'(op_sel),  512'(0));
      chk("rst_p512",    p512,          512'(0));
    end else begin
      exp_mv = (m_st == M_BUSY) && (m_op != 2'b11) && (m_age >= m_wstart);
      chk("req_rdy", 512'(req_rdy), 512'(m_st == M_IDLE));
      chk("rsp_vld", 512'(rsp_vld), 512'(m_st == M_RESP));
      chk("mod_vld", 512'(mod_vld), 512'(exp_mv));
      chk("op_sel",  512'(op_sel),  512'(m_op));
      if (exp_mv) chk("p512", p512, m_p512);
      if (m_st == M_RESP) begin
        chk("rsp_res", 512'(rsp_res), 512'(m_res));
        chk("rsp_err", 512'(rsp_err), 512'(m_err));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [255:0] a, input logic [255:0] b,
                       output int t0);
    req_op  = op;
    req_a   = a;
    req_b   = b;
    req_vld = 1'b1;
    t0      = cyc;
    step();
    req_vld = 1'b0;
  endtask

  task automatic collect(input string name, input int t0, input int lat,
                         input logic [255:0] res, input logic err, input int hold);
    int w;
    w = 0;
    while (rsp_vld !== 1'b1 && w < 300) begin
      step();
      w++;
    end
    if (rsp_vld !== 1'b1) begin
      chk({name, "_rsp_seen"}, 512'(rsp_vld), 512'(1));
      return;
    end
    chk({name, "_lat"}, 512'(cyc - t0), 512'(lat));
    chk({name, "_res"}, 512'(rsp_res), 512'(res));
    chk({name, "_err"}, 512'(rsp_err), 512'(err));
    repeat (hold) step();
    rsp_rdy = 1'b1;
    step();
    rsp_rdy = 1'b0;
  endtask

  initial begin
    int t0;
    logic [255:0] pm1;
    pm1 = P - 256'd1;

    repeat (3) step();
    rst = 1'b0;
    while (cyc < 10) step();

    // MUL 3*5 accepted at cycle 10
    issue(2'b00, 256'd3, 256'd5, t0);
    while (cyc < 14) step();
    chk("mul1_modvld_pre", 512'(mod_vld), 512'(0));
    step();
    chk("mul1_modvld_rise", 512'(mod_vld), 512'(1));
    chk("mul1_p512", p512, 512'd15);
    repeat (3) step();
    chk("mul1_fin", 512'(mod_fin), 512'(1));
    collect("mul1", t0, 9, 256'd15, 1'b0, 0);

    // ADD wraps, SUB borrows
    issue(2'b01, pm1, 256'd2, t0);
    collect("add_wrap", t0, 2, 256'd1, 1'b0, 0);
    issue(2'b10, 256'd1, 256'd2, t0);
    collect("sub_borrow", t0, 2, pm1, 1'b0, 0);

    // back-to-back MUL then ADD
    issue(2'b00, pm1, pm1, t0);
    collect("b2b_mul", t0, 9, 256'd1, 1'b0, 0);
    issue(2'b01, 256'd0, 256'd0, t0);
    collect("b2b_add", t0, 2, 256'd0, 1'b0, 0);

    // response backpressure with the next request already waiting
    issue(2'b01, 256'd5, 256'd6, t0);
    step();
    chk("bp_vld", 512'(rsp_vld), 512'(1));
    chk("bp_res", 512'(rsp_res), 512'd11);
    req_op  = 2'b10;
    req_a   = 256'd10;
    req_b   = 256'd3;
    req_vld = 1'b1;
    repeat (5) begin
      step();
      chk("bp_hold_vld", 512'(rsp_vld), 512'(1));
      chk("bp_hold_res", 512'(rsp_res), 512'd11);
      chk("bp_hold_rdy", 512'(req_rdy), 512'(0));
    end
    rsp_rdy = 1'b1;
    step();
    rsp_rdy = 1'b0;
    t0 = cyc;
    chk("bp_idle_rdy", 512'(req_rdy), 512'(1));
    step();
    req_vld = 1'b0;
    collect("bp_sub", t0, 2, 256'd7, 1'b0, 0);

    // illegal op
    issue(2'b11, 256'd1, 256'd2, t0);
    collect("illegal", t0, 1, 256'd0, 1'b1, 0);

    // reducer never finishes
    stub_on = 1'b0;
    issue(2'b01, 256'd1, 256'd1, t0);
    collect("timeout_add", t0, 17, 256'd0, 1'b1, 0);
    stub_on = 1'b1;

    // reset in the middle of a MUL
    issue(2'b00, 256'd7, 256'd9, t0);
    step();
    rst = 1'b1;
    #1;
    chk("midrst_mod_vld", 512'(mod_vld), 512'(0));
    chk("midrst_rsp_vld", 512'(rsp_vld), 512'(0));
    chk("midrst_p512",    p512,          512'(0));
    chk("midrst_req_rdy", 512'(req_rdy), 512'(1));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (12) step();
    issue(2'b00, 256'd2, 256'd2, t0);
    collect("post_rst_mul", t0, 9, 256'd4, 1'b0, 0);

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule

// File: doc/sm2_mod_op_issuer.md
# sm2_mod_op_issuer

Front-end issuer for the SM2 modular arithmetic datapath. It accepts one MUL/ADD/SUB request at a time over a valid/ready port. For MUL it builds the 512-bit product with an iterative multiplier. It drives the fast-reduction block's start/operand interface, waits for that block's finish strobe and captures the 256-bit result. It returns the result over a valid/ready response port. It sits between the point-arithmetic sequencer and the reduction / mod-add-sub unit.

## Interface
Parameters:
- MUL_W, 64, multiplier slice width; legal 32/64/128/256; N = 256/MUL_W multiply cycles
- TIMEOUT, 15, max cycles in WAIT without mod_fin_i before an error response

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_vld_i  in  1  request valid
- req_rdy_o  out  1  request ready (high only in IDLE)
- req_op_i  in  2  00 MUL, 01 ADD, 10 SUB, 11 illegal
- req_a_i  in  256  operand a (< p)
- req_b_i  in  256  operand b (< p)
- rsp_vld_o  out  1  response valid
- rsp_rdy_i  in  1  response ready
- rsp_res_o  out  256  result
- rsp_err_o  out  1  illegal op or timeout
- mod_vld_o  out  1  start level to reducer; the reducer starts on its rising edge
- op_sel_o  out  2  op code to reducer
- p512_a_o  out  512  MUL: product; ADD/SUB: {a,b}
- mod_fin_i  in  1  reducer finish strobe
- mul_res_i  in  256  reducer MUL result, valid when mod_fin_i=1
- add_sub_res_i  in  256  reducer ADD/SUB result, valid combinationally when mod_fin_i=1

## Operation
- States: IDLE, MUL, WAIT, RESP.
- IDLE: req_rdy_o=1. On req_vld_i, capture a, b and op; set op_sel_o=op. MUL goes to MUL. ADD/SUB goes to WAIT with p512_a_o={a,b}. Op 11 goes to RESP with rsp_res_o=0 and rsp_err_o=1, and no reducer transaction occurs.
- MUL: acc cleared at accept. Slice counter k runs 0..N-1; each cycle acc += a * b[k*MUL_W +: MUL_W] << (k*MUL_W). acc is 512 bits and never overflows because a, b < 2^256. After k=N-1, p512_a_o=acc and the state goes to WAIT.
- WAIT: mod_vld_o=1. p512_a_o and op_sel_o are held constant for the whole state. A cycle counter starts at 0.
- WAIT, mod_fin_i=1: capture mul_res_i (MUL) or add_sub_res_i (ADD/SUB) into rsp_res_o, set rsp_err_o=0, go to RESP.
- WAIT, counter reaches TIMEOUT with no mod_fin_i: rsp_res_o=0, rsp_err_o=1, go to RESP.
- RESP: rsp_vld_o=1 and mod_vld_o=0; rsp_res_o and rsp_err_o are stable. On rsp_rdy_i, go to IDLE.
- mod_vld_o is low for ≥2 cycles between reducer transactions (RESP plus IDLE). Every new op therefore produces a fresh rising edge.
- op_sel_o holds its last value in IDLE and RESP and changes only at accept. This keeps the reducer's MUL pipeline advancing until it finishes.
- mod_fin_i outside WAIT is ignored.

## Timing
- Reset values: req_rdy_o=1 (IDLE); rsp_vld_o=0; rsp_res_o=0; rsp_err_o=0; mod_vld_o=0; op_sel_o=00; p512_a_o=0. Internal acc, counters and state are cleared.
- Reset mid-operation: all outputs return to reset values asynchronously and mod_vld_o drops immediately. The transaction is discarded with no response.
- All outputs are registered, except req_rdy_o, which decodes the state.
- MUL, accept at cycle T:
  - MUL state T+1..T+N;
  - WAIT entered at T+N+1 (mod_vld_o rising edge);
  - the reducer asserts mod_fin_i at T+N+4;
  - rsp_vld_o at T+N+5 (T+9 for MUL_W=64).
- ADD/SUB, accept at T: WAIT at T+1, mod_fin_i is seen that same cycle, rsp_vld_o at T+2.
- Illegal op, accept at T: rsp_vld_o at T+1.
- Timeout, accept at T: rsp_vld_o at T+N+1+TIMEOUT+1 for MUL, or T+TIMEOUT+2 for ADD/SUB.
- Throughput: one request in flight. The next accept comes no earlier than the cycle after the response handshake.
- Response backpressure: the block holds RESP indefinitely and keeps req_rdy_o=0.

## Test plan
- MUL a=3, b=5 with the real reduction block attached, accept at T=10 → p512_a_o=15 and mod_vld_o rising at 15, mod_fin_i at 18, rsp_vld_o at 19 with rsp_res_o=15, rsp_err_o=0.
- ADD a=p−1, b=2 → rsp_res_o=1 at T+2. SUB a=1, b=2 → rsp_res_o=p−1. In both cases mod_vld_o is high for exactly 1 cycle.
- Back-to-back: MUL a=p−1, b=p−1, then ADD 0+0 with rsp_rdy_i=1 → results 1 then 0. mod_vld_o is low ≥2 cycles between them and op_sel_o is held at 00 until the MUL response.
- Backpressure: rsp_rdy_i low for 5 cycles → rsp_vld_o and rsp_res_o stay stable and req_rdy_o=0 with req_vld_i held. The next request is accepted the cycle after rsp_rdy_i rises.
- Error paths:
  - op=11 → rsp_err_o=1 and rsp_res_o=0 at T+1, mod_vld_o never rises;
  - reducer stub that never finishes, ADD → rsp_err_o=1 at T+17 (TIMEOUT=15).
- Reset: assert rst at T+2 of a MUL → mod_vld_o, rsp_vld_o and p512_a_o are 0 immediately and no response is seen. After release, MUL a=2, b=2 returns 4 normally.
